bck_mem_req_queue: RTL

- Downstream of the backward control pipeline (CAL_KL output stage).
- Accepts one BWT occurrence request per cycle: request_valid, addr_k, addr_l, read_num. Buffers requests in a FIFO.
- Serialises each request into two single-address memory read beats, K then L, over a valid/ready interface, and limits outstanding reads.
- Raises a stall request back to the pipeline before the FIFO can overflow.

---
 rtl/bck_mem_req_queue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bck_mem_req_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bck_mem_req_queue                                                         |
// | Buffers K/L occurrence requests and issues them as credit-limited beats.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bck_mem_req_queue #(
  parameter int DEPTH           = 16,
  parameter int AW              = 42,
  parameter int RW              = 10,
  parameter int AFULL_MARGIN    = 4,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     request_valid,
  input  logic [RW-1:0]            read_num,
  input  logic [AW-1:0]            addr_k,
  input  logic [AW-1:0]            addr_l,
  output logic                     stall_req,
  output logic                     mem_req_valid,
  output logic [AW-1:0]            mem_req_addr,
  output logic [RW:0]              mem_req_tag,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE_K = 2'd1,
    S_ISSUE_L = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [c_CW-1:0]   w_count_next;
  logic [c_OW-1:0]   r_out;
  logic [c_OW-1:0]   w_out_next;
  logic              r_stall_req;
  logic              r_overflow;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_beat;
  logic              w_rsp;

  logic [AW-1:0]     r_mem_k  [DEPTH];
  logic [AW-1:0]     r_mem_l  [DEPTH];
  logic [RW-1:0]     r_mem_rn [DEPTH];

  // Full test uses the registered count, so a same-cycle pop never rescues a push.
  assign w_push_req = request_valid && !stall;
  assign w_push_ok  = w_push_req && (r_count != c_CW'(DEPTH));
  assign w_pop      = (r_state == S_ISSUE_L) && mem_req_ready;
  assign w_beat     = (r_state != S_IDLE) && mem_req_ready;
  assign w_rsp      = mem_rsp_valid && (r_out != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop)
      w_count_next = r_count + c_CW'(1);
    else if (!w_push_ok && w_pop)
      w_count_next = r_count - c_CW'(1);
  end

  always_comb begin
    w_out_next = r_out;
    if (w_beat && !w_rsp)
      w_out_next = r_out + c_OW'(1);
    else if (!w_beat && w_rsp)
      w_out_next = r_out - c_OW'(1);
  end

  always_comb begin
    w_state_next  = r_state;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_tag   = '0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && (r_out <= c_OW'(MAX_OUTSTANDING - 2)))
          w_state_next = S_ISSUE_K;
      end
      S_ISSUE_K: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_mem_k[r_rd_ptr];
        mem_req_tag   = {r_mem_rn[r_rd_ptr], 1'b0};
        if (mem_req_ready)
          w_state_next = S_ISSUE_L;
      end
      S_ISSUE_L: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_mem_l[r_rd_ptr];
        mem_req_tag   = {r_mem_rn[r_rd_ptr], 1'b1};
        // Credit for the next pair is judged against the count including this L beat.
        if (mem_req_ready) begin
          if ((r_count > c_CW'(1)) && (w_out_next <= c_OW'(MAX_OUTSTANDING - 2)))
            w_state_next = S_ISSUE_K;
          else
            w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_stall_req <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_out       <= w_out_next;
      r_stall_req <= (w_count_next >= c_CW'(DEPTH - AFULL_MARGIN));
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      if (w_push_req && !w_push_ok)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_k[r_wr_ptr]  <= addr_k;
      r_mem_l[r_wr_ptr]  <= addr_l;
      r_mem_rn[r_wr_ptr] <= read_num;
    end
  end

  assign stall_req    = r_stall_req;
  assign occupancy    = r_count;
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire
